// File: rtl/led_hc595_driver.sv
// led_hc595_driver
// Serialises a 16-bit LED pattern onto two daisy-chained 74HC595 shift
// registers. A frame is sent only when the pattern differs from the last one
// sent, when an update is forced, or once after reset. All 595 control pins
// are driven straight from flops so they cannot glitch.
module led_hc595_driver #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned LED_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_W-1:0] led_in,
    input  logic             force_update,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             oe_n,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_CLK_HI   = 3'd2,
        ST_LATCH_HI = 3'd3,
        ST_LATCH_LO = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Last divider count of a half-phase and index of the final bit.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(LED_W - 1);

    state_t             state_r;
    logic [7:0]         div_r;
    logic [3:0]         bit_cnt_r;
    logic [LED_W-1:0]   shift_r;
    logic [LED_W-1:0]   last_sent_r;
    logic               pending_r;
    logic               first_frame_r;

    logic               start_s;
    logic               div_end_s;

    // A frame is due when the pattern moved, a resend was asked for (now or
    // during the previous frame), or nothing valid has been latched yet.
    assign start_s   = (led_in != last_sent_r) | force_update | pending_r | first_frame_r;
    assign div_end_s = (div_r == DIV_LAST);

    // Frame sequencer: owns every state register and every output pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            div_r         <= 8'd0;
            bit_cnt_r     <= 4'd0;
            shift_r       <= '0;
            last_sent_r   <= '0;
            pending_r     <= 1'b0;
            first_frame_r <= 1'b1;
            ser           <= 1'b0;
            srclk         <= 1'b0;
            rclk          <= 1'b0;
            oe_n          <= 1'b1;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            // Resend requests arriving while a frame is in flight collapse
            // into one pending flag that is honoured on return to IDLE.
            if ((state_r != ST_IDLE) && force_update) begin
                pending_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    frame_done <= 1'b0;
                    rclk       <= 1'b0;
                    srclk      <= 1'b0;
                    if (start_s) begin
                        // Snapshot the pattern; later changes wait for the
                        // next IDLE comparison, so only the newest is sent.
                        shift_r       <= led_in;
                        last_sent_r   <= led_in;
                        pending_r     <= 1'b0;
                        first_frame_r <= 1'b0;
                        busy          <= 1'b1;
                        ser           <= led_in[LED_W-1];
                        div_r         <= 8'd0;
                        bit_cnt_r     <= 4'd0;
                        state_r       <= ST_SETUP;
                    end else begin
                        ser <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    // ser already stable; raise srclk after a full half-phase.
                    if (div_end_s) begin
                        div_r   <= 8'd0;
                        srclk   <= 1'b1;
                        state_r <= ST_CLK_HI;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_CLK_HI: begin
                    if (div_end_s) begin
                        div_r <= 8'd0;
                        srclk <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            rclk    <= 1'b1;
                            state_r <= ST_LATCH_HI;
                        end else begin
                            // ser moves together with the falling srclk edge,
                            // keeping it steady around each rising edge.
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            shift_r   <= {shift_r[LED_W-2:0], 1'b0};
                            ser       <= shift_r[LED_W-2];
                            state_r   <= ST_SETUP;
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_LATCH_HI: begin
                    if (div_end_s) begin
                        div_r   <= 8'd0;
                        rclk    <= 1'b0;
                        state_r <= ST_LATCH_LO;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_LATCH_LO: begin
                    if (div_end_s) begin
                        // Valid data now sits in the 595 outputs: unblank.
                        div_r      <= 8'd0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        ser        <= 1'b0;
                        oe_n       <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_DONE: begin
                    frame_done <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    div_r      <= 8'd0;
                    bit_cnt_r  <= 4'd0;
                    ser        <= 1'b0;
                    srclk      <= 1'b0;
                    rclk       <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_hc595_driver.sv
// Testbench for led_hc595_driver: two instances (CLK_DIV=2 and CLK_DIV=1)
// each observed by a behavioural 74HC595 model that captures ser on srclk
// rising edges and latches the captured word on rclk rising edges.
module tb_led_hc595_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led_a, led_b;
    logic        fu_a, fu_b;

    logic [1:0]  ser_w, srclk_w, rclk_w, oe_n_w, busy_w, done_w;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    led_hc595_driver #(.CLK_DIV(2), .LED_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .led_in(led_a), .force_update(fu_a),
        .ser(ser_w[0]), .srclk(srclk_w[0]), .rclk(rclk_w[0]),
        .oe_n(oe_n_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
    );

    led_hc595_driver #(.CLK_DIV(1), .LED_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .led_in(led_b), .force_update(fu_b),
        .ser(ser_w[1]), .srclk(srclk_w[1]), .rclk(rclk_w[1]),
        .oe_n(oe_n_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
    );

    // 595 model and activity counters, sampled mid-cycle.
    int          sr_rises [2];
    int          rc_rises [2];
    int          done_cnt [2];
    int          busy_run [2];
    int          busy_len [2];
    int          busy_cyc [2];
    int          unstable [2];
    logic [15:0] cap [2];
    logic [15:0] latched [2];
    logic [1:0]  srclk_q, rclk_q, ser_q;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (srclk_w[k] === 1'b1 && srclk_q[k] === 1'b0) begin
                sr_rises[k]++;
                cap[k] = {cap[k][14:0], ser_w[k]};
                if (ser_w[k] !== ser_q[k]) unstable[k]++;
            end
            if (rclk_w[k] === 1'b1 && rclk_q[k] === 1'b0) begin
                rc_rises[k]++;
                latched[k] = cap[k];
            end
            if (busy_w[k] === 1'b1) begin
                busy_run[k]++;
                busy_cyc[k]++;
            end else if (busy_run[k] != 0) begin
                busy_len[k] = busy_run[k];
                busy_run[k] = 0;
            end
            if (done_w[k] === 1'b1) done_cnt[k]++;
        end
        srclk_q = srclk_w;
        rclk_q  = rclk_w;
        ser_q   = ser_w;
    end

    // Wait (bounded) for a frame_done pulse on instance k.
    task automatic wait_done(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (done_w[k] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        int s0, r0;
        rst_n = 1'b0; led_a = 16'h8000; led_b = 16'h0000; fu_a = 1'b0; fu_b = 1'b0;
        idle_cycles(3);
        n_checks++;
        if ({ser_w[0], srclk_w[0], rclk_w[0], oe_n_w[0], busy_w[0], done_w[0]} !== 6'b000100) begin
            n_fails++; $display("FAIL reset_a: got %b expected 000100", {ser_w[0], srclk_w[0], rclk_w[0], oe_n_w[0], busy_w[0], done_w[0]});
        end
        n_checks++;
        if ({ser_w[1], srclk_w[1], rclk_w[1], oe_n_w[1], busy_w[1], done_w[1]} !== 6'b000100) begin
            n_fails++; $display("FAIL reset_b: got %b expected 000100", {ser_w[1], srclk_w[1], rclk_w[1], oe_n_w[1], busy_w[1], done_w[1]});
        end
        s0 = sr_rises[0]; r0 = rc_rises[0];
        rst_n = 1'b1;
        idle_cycles(1);
        n_checks++;
        if (busy_w[0] !== 1'b1) begin
            n_fails++; $display("FAIL first_start: busy got %b expected 1", busy_w[0]);
        end
        n_checks++;
        if (oe_n_w[0] !== 1'b1) begin
            n_fails++; $display("FAIL oe_blank: oe_n got %b expected 1", oe_n_w[0]);
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fails++; $display("FAIL first_done: no frame_done within 200 cycles");
        end
        n_checks++;
        if (busy_len[0] != 68) begin
            n_fails++; $display("FAIL first_busy_len: got %0d expected 68", busy_len[0]);
        end
        n_checks++;
        if (oe_n_w[0] !== 1'b0) begin
            n_fails++; $display("FAIL oe_at_done: oe_n got %b expected 0", oe_n_w[0]);
        end
        n_checks++;
        if (sr_rises[0] - s0 != 16 || rc_rises[0] - r0 != 1) begin
            n_fails++; $display("FAIL first_edges: srclk %0d rclk %0d expected 16 1", sr_rises[0] - s0, rc_rises[0] - r0);
        end
        n_checks++;
        if (latched[0] !== 16'h8000) begin
            n_fails++; $display("FAIL first_data: got %h expected 8000", latched[0]);
        end
        n_checks++;
        if (done_cnt[1] != 1 || latched[1] !== 16'h0000 || oe_n_w[1] !== 1'b0) begin
            n_fails++; $display("FAIL first_zero_b: frames %0d data %h oe_n %b expected 1 0000 0", done_cnt[1], latched[1], oe_n_w[1]);
        end
    endtask

    task automatic test_steady();
        bit ok;
        int s0, r0, b0, d0;
        @(posedge clk); #1; led_a = 16'hA5C3;
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'hA5C3) begin
            n_fails++; $display("FAIL steady_first: ok %0d data %h expected 1 a5c3", ok, latched[0]);
        end
        s0 = sr_rises[0]; r0 = rc_rises[0]; b0 = busy_cyc[0];
        idle_cycles(500);
        n_checks++;
        if (sr_rises[0] != s0 || rc_rises[0] != r0 || busy_cyc[0] != b0) begin
            n_fails++; $display("FAIL steady_quiet: srclk %0d rclk %0d busy %0d expected 0 0 0", sr_rises[0] - s0, rc_rises[0] - r0, busy_cyc[0] - b0);
        end
        n_checks++;
        if ({ser_w[0], srclk_w[0], rclk_w[0]} !== 3'b000) begin
            n_fails++; $display("FAIL steady_pins: got %b expected 000", {ser_w[0], srclk_w[0], rclk_w[0]});
        end
        d0 = done_cnt[0]; s0 = sr_rises[0];
        @(posedge clk); #1; led_a = 16'h0180;
        wait_done(0, 200, ok);
        idle_cycles(150);
        n_checks++;
        if (!ok || latched[0] !== 16'h0180) begin
            n_fails++; $display("FAIL change_data: ok %0d data %h expected 1 0180", ok, latched[0]);
        end
        n_checks++;
        if (done_cnt[0] - d0 != 1 || sr_rises[0] - s0 != 16) begin
            n_fails++; $display("FAIL change_once: frames %0d srclk %0d expected 1 16", done_cnt[0] - d0, sr_rises[0] - s0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        d0 = done_cnt[0];
        @(posedge clk); #1; led_a = 16'h0001;
        repeat (10) @(posedge clk); #1; led_a = 16'h0002;
        repeat (10) @(posedge clk); #1; led_a = 16'h0004;
        repeat (10) @(posedge clk); #1; led_a = 16'h0008;
        n_checks++;
        if (busy_w[0] !== 1'b1) begin
            n_fails++; $display("FAIL b2b_busy: busy got %b expected 1", busy_w[0]);
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'h0001) begin
            n_fails++; $display("FAIL b2b_first: ok %0d data %h expected 1 0001", ok, latched[0]);
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'h0008) begin
            n_fails++; $display("FAIL b2b_newest: ok %0d data %h expected 1 0008", ok, latched[0]);
        end
        idle_cycles(200);
        n_checks++;
        if (done_cnt[0] - d0 != 2) begin
            n_fails++; $display("FAIL b2b_count: frames %0d expected 2", done_cnt[0] - d0);
        end
    endtask

    task automatic test_force();
        bit ok;
        int d0;
        d0 = done_cnt[0];
        @(posedge clk); #1; fu_a = 1'b1;
        @(posedge clk); #1; fu_a = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (10) @(posedge clk); #1; fu_a = 1'b1;
            @(posedge clk); #1; fu_a = 1'b0;
        end
        n_checks++;
        if (busy_w[0] !== 1'b1) begin
            n_fails++; $display("FAIL force_inflight: busy got %b expected 1", busy_w[0]);
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'h0008) begin
            n_fails++; $display("FAIL force_first: ok %0d data %h expected 1 0008", ok, latched[0]);
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'h0008) begin
            n_fails++; $display("FAIL force_extra: ok %0d data %h expected 1 0008", ok, latched[0]);
        end
        idle_cycles(200);
        n_checks++;
        if (done_cnt[0] - d0 != 2 || busy_w[0] !== 1'b0) begin
            n_fails++; $display("FAIL force_count: frames %0d busy %b expected 2 0", done_cnt[0] - d0, busy_w[0]);
        end
        d0 = done_cnt[0];
        @(posedge clk); #1; led_a = 16'h0F0F; fu_a = 1'b1;
        @(posedge clk); #1; fu_a = 1'b0;
        wait_done(0, 200, ok);
        idle_cycles(200);
        n_checks++;
        if (!ok || done_cnt[0] - d0 != 1 || latched[0] !== 16'h0F0F) begin
            n_fails++; $display("FAIL force_with_change: ok %0d frames %0d data %h expected 1 1 0f0f", ok, done_cnt[0] - d0, latched[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int s0, r0;
        s0 = sr_rises[0];
        @(posedge clk); #1; led_a = 16'h1234;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (sr_rises[0] - s0 == 8) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fails++; $display("FAIL mid_reach_bit7: srclk rises %0d expected 8", sr_rises[0] - s0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_w[0], srclk_w[0], rclk_w[0], oe_n_w[0], busy_w[0], done_w[0]} !== 6'b000100) begin
            n_fails++; $display("FAIL mid_reset_pins: got %b expected 000100", {ser_w[0], srclk_w[0], rclk_w[0], oe_n_w[0], busy_w[0], done_w[0]});
        end
        idle_cycles(1);
        rst_n = 1'b1;
        s0 = sr_rises[0]; r0 = rc_rises[0];
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || latched[0] !== 16'h1234) begin
            n_fails++; $display("FAIL mid_resend: ok %0d data %h expected 1 1234", ok, latched[0]);
        end
        n_checks++;
        if (sr_rises[0] - s0 != 16 || rc_rises[0] - r0 != 1 || oe_n_w[0] !== 1'b0) begin
            n_fails++; $display("FAIL mid_edges: srclk %0d rclk %0d oe_n %b expected 16 1 0", sr_rises[0] - s0, rc_rises[0] - r0, oe_n_w[0]);
        end
    endtask

    task automatic test_clkdiv1();
        bit ok;
        logic [15:0] exp_v;
        idle_cycles(20);
        for (int i = 0; i < 16; i++) begin
            exp_v = 16'h0001 << i;
            @(posedge clk); #1; led_b = exp_v;
            wait_done(1, 100, ok);
            n_checks++;
            if (!ok || busy_len[1] != 34) begin
                n_fails++; $display("FAIL div1_busy[%0d]: ok %0d busy %0d expected 1 34", i, ok, busy_len[1]);
            end
            n_checks++;
            if (latched[1] !== exp_v) begin
                n_fails++; $display("FAIL div1_data[%0d]: got %h expected %h", i, latched[1], exp_v);
            end
        end
        n_checks++;
        if (unstable[0] != 0 || unstable[1] != 0) begin
            n_fails++; $display("FAIL ser_stable: unstable a %0d b %0d expected 0 0", unstable[0], unstable[1]);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_back_to_back();
        test_force();
        test_reset_mid();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
